// File: rtl/memory_writeback_unit.sv
// rtl/memory_writeback_unit.sv - EXE->MEM register, data memory, MEM->WB register and write-back select
module memory_writeback_unit #(
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        writeBackEnIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [31:0] aluResultIn,
  input  logic [31:0] storeValIn,
  input  logic [3:0]  destinationIn,
  output logic [3:0]  destMEM,
  output logic        writeBackEnMEM,
  output logic [3:0]  destWB,
  output logic [31:0] resultWB,
  output logic        writeBackEnWB,
  output logic        addrError
);

  localparam int          IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * MEM_DEPTH);

  // EXE->MEM pipeline register contents
  logic        writeBackEnM;
  logic        memReadM;
  logic        memWriteM;
  logic [31:0] aluResultM;
  logic [31:0] storeValM;
  logic [3:0]  destM;

  // MEM->WB pipeline register contents
  logic        writeBackEnW;
  logic        memReadW;
  logic [3:0]  destW;
  logic [31:0] aluResultW;
  logic [31:0] loadDataW;

  logic [31:0] mem [MEM_DEPTH];

  logic [31:0]      offset;
  logic             accessValid;
  logic [IDX_W-1:0] wordIdx;
  logic [31:0]      loadData;
  logic             badAccess;

  // Addresses below BASE_ADDR underflow to a huge offset, so one unsigned
  // compare rejects both ends of the window without any modular wrap.
  always_comb begin
    offset      = aluResultM - BASE_ADDR;
    accessValid = (offset < SPAN) && (aluResultM[1:0] == 2'b00);
    wordIdx     = offset[IDX_W+1:2];
    loadData    = (memReadM && accessValid) ? mem[wordIdx] : 32'h0;
    badAccess   = (memReadM || memWriteM) && !accessValid;
  end

  // Both pipeline registers plus the sticky address-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      writeBackEnM <= 1'b0;
      memReadM     <= 1'b0;
      memWriteM    <= 1'b0;
      aluResultM   <= '0;
      storeValM    <= '0;
      destM        <= '0;
      writeBackEnW <= 1'b0;
      memReadW     <= 1'b0;
      destW        <= '0;
      aluResultW   <= '0;
      loadDataW    <= '0;
      addrError    <= 1'b0;
    end else begin
      writeBackEnM <= writeBackEnIn;
      memReadM     <= memReadIn;
      memWriteM    <= memWriteIn;
      aluResultM   <= aluResultIn;
      storeValM    <= storeValIn;
      destM        <= destinationIn;
      writeBackEnW <= writeBackEnM;
      memReadW     <= memReadM;
      destW        <= destM;
      aluResultW   <= aluResultM;
      loadDataW    <= loadData;
      if (badAccess) addrError <= 1'b1;
    end
  end

  // Data memory: the load above samples the old word, so a combined
  // load/store in one MEM cycle reads before it writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (memWriteM && accessValid) begin
      mem[wordIdx] <= storeValM;
    end
  end

  assign destMEM        = destM;
  assign writeBackEnMEM = writeBackEnM;
  assign destWB         = destW;
  assign writeBackEnWB  = writeBackEnW;
  assign resultWB       = memReadW ? loadDataW : aluResultW;

endmodule

// File: tb/tb_memory_writeback_unit.sv
// tb/tb_memory_writeback_unit.sv - directed self-checking bench for memory_writeback_unit
module tb_memory_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        writeBackEnIn;
  logic        memReadIn;
  logic        memWriteIn;
  logic [31:0] aluResultIn;
  logic [31:0] storeValIn;
  logic [3:0]  destinationIn;
  logic [3:0]  destMEM;
  logic        writeBackEnMEM;
  logic [3:0]  destWB;
  logic [31:0] resultWB;
  logic        writeBackEnWB;
  logic        addrError;

  int checks = 0;
  int errors = 0;

  memory_writeback_unit #(.MEM_DEPTH(64), .BASE_ADDR(32'd1024)) dut (
    .clk            (clk),
    .rst            (rst),
    .writeBackEnIn  (writeBackEnIn),
    .memReadIn      (memReadIn),
    .memWriteIn     (memWriteIn),
    .aluResultIn    (aluResultIn),
    .storeValIn     (storeValIn),
    .destinationIn  (destinationIn),
    .destMEM        (destMEM),
    .writeBackEnMEM (writeBackEnMEM),
    .destWB         (destWB),
    .resultWB       (resultWB),
    .writeBackEnWB  (writeBackEnWB),
    .addrError      (addrError)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wbEn, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] sv, input logic [3:0] dest);
    writeBackEnIn = wbEn;
    memReadIn     = rd;
    memWriteIn    = wr;
    aluResultIn   = alu;
    storeValIn    = sv;
    destinationIn = dest;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // put data at 1024 so the reset test proves memory is cleared
    drive(1'b0, 1'b0, 1'b1, 32'd1024, 32'hAAAA5555, 4'h0);
    tick();
    idle();
    tick();

    // reset with junk inputs
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'd1024, 32'hFFFFFFFF, 4'h7);
    tick();
    rst = 1'b0;
    idle();
    checkVal("rst_destMEM", destMEM, 32'd0);
    checkVal("rst_wbEnMEM", writeBackEnMEM, 32'd0);
    checkVal("rst_destWB", destWB, 32'd0);
    checkVal("rst_resultWB", resultWB, 32'd0);
    checkVal("rst_wbEnWB", writeBackEnWB, 32'd0);
    checkVal("rst_addrError", addrError, 32'd0);

    // load at 1024 after reset
    drive(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'h2);
    tick();
    idle();
    tick();
    checkVal("rstload_result", resultWB, 32'h0);
    checkVal("rstload_dest", destWB, 32'd2);
    checkVal("rstload_wbEn", writeBackEnWB, 32'd1);

    // ALU pass-through
    drive(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 4'h5);
    tick();
    checkVal("pass_destMEM", destMEM, 32'd5);
    checkVal("pass_wbEnMEM", writeBackEnMEM, 32'd1);
    idle();
    tick();
    checkVal("pass_destWB", destWB, 32'd5);
    checkVal("pass_resultWB", resultWB, 32'hDEADBEEF);
    checkVal("pass_wbEnWB", writeBackEnWB, 32'd1);
    checkVal("pass_addrError", addrError, 32'd0);

    // back-to-back store then load
    drive(1'b0, 1'b0, 1'b1, 32'd1032, 32'h12345678, 4'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'h3);
    tick();
    checkVal("st_wbEnWB", writeBackEnWB, 32'd0);
    idle();
    tick();
    checkVal("ld_resultWB", resultWB, 32'h12345678);
    checkVal("ld_destWB", destWB, 32'd3);

    // read-before-write with both controls set
    drive(1'b0, 1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 4'h0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'd1036, 32'h22222222, 4'h8);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'h9);
    tick();
    checkVal("rbw_old", resultWB, 32'h0BADF00D);
    checkVal("rbw_dest", destWB, 32'd8);
    idle();
    tick();
    checkVal("rbw_new", resultWB, 32'h22222222);

    // top word of the window
    drive(1'b0, 1'b0, 1'b1, 32'd1276, 32'hCAFEF00D, 4'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd1276, 32'h0, 4'h4);
    tick();
    idle();
    tick();
    checkVal("top_result", resultWB, 32'hCAFEF00D);
    checkVal("top_addrError", addrError, 32'd0);

    // one past the window
    drive(1'b0, 1'b0, 1'b1, 32'd1280, 32'h11111111, 4'h0);
    tick();
    checkVal("over_err_before", addrError, 32'd0);
    idle();
    tick();
    checkVal("over_err_after", addrError, 32'd1);

    // idle access with an out-of-range address must not flag
    doReset();
    drive(1'b1, 1'b0, 1'b0, 32'd1020, 32'h0, 4'h6);
    tick();
    idle();
    tick();
    checkVal("idle_addrError", addrError, 32'd0);
    checkVal("idle_result", resultWB, 32'd1020);

    // underflow load; word 63 holds data so a wrapped index would show
    drive(1'b0, 1'b0, 1'b1, 32'd1276, 32'hCAFEF00D, 4'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd1020, 32'h0, 4'h6);
    tick();
    idle();
    tick();
    checkVal("under_result", resultWB, 32'h0);
    checkVal("under_addrError", addrError, 32'd1);

    // misaligned load; word 0 holds data so a truncated index would show
    doReset();
    checkVal("mis_pre_err", addrError, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'd1024, 32'h5A5A5A5A, 4'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd1026, 32'h0, 4'h1);
    tick();
    idle();
    tick();
    checkVal("mis_result", resultWB, 32'h0);
    checkVal("mis_addrError", addrError, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    checkVal("mis_sticky", addrError, 32'd1);
    doReset();
    checkVal("mis_cleared", addrError, 32'd0);

    // reset while a store sits in MEM, with an ALU op behind it in WB
    drive(1'b1, 1'b0, 1'b0, 32'h00000042, 32'h0, 4'hA);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'd1040, 32'h77777777, 4'h0);
    tick();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    checkVal("midrst_wbEnWB", writeBackEnWB, 32'd0);
    checkVal("midrst_resultWB", resultWB, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'hB);
    tick();
    idle();
    tick();
    checkVal("midrst_load", resultWB, 32'h0);
    checkVal("midrst_dest", destWB, 32'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
